// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: shared widths and queue entry type for the writeback queue.
package regfile_write_queue_pkg;
    localparam int REG_IDX_W    = 5;
    localparam int DATA_W       = 64;
    localparam int ZERO_REG_IDX = 31;
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_write_queue_hazard_match.sv
// hazard_match: pending lookup of one read address against queued and in-flight writes.
// Youngest-data forwarding is only built when WB_FORWARD_EN is defined.
module hazard_match
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = ZERO_REG_IDX,
    localparam int PW      = $clog2(DEPTH)
) (
`ifdef WB_FORWARD_EN
    input  logic [PW-1:0]        i_head,
    input  logic [DATA_W-1:0]    i_data [DEPTH],
    input  logic [DATA_W-1:0]    i_out_data,
    output logic [DATA_W-1:0]    o_fwd,
`endif
    input  logic                 i_valid [DEPTH],
    input  logic [REG_IDX_W-1:0] i_dst [DEPTH],
    input  logic                 i_out_valid,
    input  logic [REG_IDX_W-1:0] i_out_reg,
    input  logic [REG_IDX_W-1:0] i_addr,
    output logic                 o_pending
);
    logic w_live;
    assign w_live = i_addr != REG_IDX_W'(ZERO_REG);
`ifdef WB_FORWARD_EN
    logic [PW-1:0] w_idx;
    // Walk oldest to newest so the last hit is the youngest; the output register is older than all.
    always_comb begin
        o_pending = i_out_valid && i_out_reg == i_addr;
        o_fwd     = o_pending ? i_out_data : '0;
        w_idx     = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] && i_dst[w_idx] == i_addr) begin
                o_pending = 1'b1;
                o_fwd     = i_data[w_idx];
            end
        end
        if (!w_live) begin
            o_pending = 1'b0;
            o_fwd     = '0;
        end
    end
`else
    always_comb begin
        o_pending = i_out_valid && i_out_reg == i_addr;
        for (int k = 0; k < DEPTH; k++)
            o_pending = o_pending || (i_valid[k] && i_dst[k] == i_addr);
        o_pending = o_pending && w_live;
    end
`endif
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of writeback results drained one per cycle into the register file.
// Define WB_FORWARD_EN to build youngest-data forwarding on fwd1/fwd2 (otherwise they are 0).
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [REG_IDX_W-1:0]     wb_reg,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     drain_hold,
    output logic [REG_IDX_W-1:0]     writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic                     REGWRITE,
    input  logic [REG_IDX_W-1:0]     read1,
    input  logic [REG_IDX_W-1:0]     read2,
    output logic                     pending1,
    output logic                     pending2,
    output logic [DATA_W-1:0]        fwd1,
    output logic [DATA_W-1:0]        fwd2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t            r_q [DEPTH];
    logic [PW-1:0]        r_head, r_tail;
    logic [CW-1:0]        r_count;
    logic [REG_IDX_W-1:0] r_wreg;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_we;
    logic                 w_push, w_pop;
    logic                 w_valid [DEPTH];
    logic [REG_IDX_W-1:0] w_dst [DEPTH];

    assign wb_ready  = r_count < CW'(DEPTH);
    assign w_push    = wb_valid && wb_ready && wb_reg != REG_IDX_W'(ZERO_REG);
    assign w_pop     = r_count != '0 && !drain_hold;
    assign writeReg  = r_wreg;
    assign writeData = r_wdata;
    assign REGWRITE  = r_we;
    assign count     = r_count;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            for (int k = 0; k < DEPTH; k++) r_q[k].valid <= 1'b0;
        end else begin
            // Push slot never equals pop slot: they coincide only when empty (no pop) or full (no push).
            if (w_push) begin
                r_q[r_tail] <= '{valid: 1'b1, dst: wb_reg, data: wb_data};
                r_tail      <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_q[r_head].valid <= 1'b0;
                r_head            <= r_head + PW'(1);
                r_wreg            <= r_q[r_head].dst;
                r_wdata           <= r_q[r_head].data;
            end
            r_we    <= w_pop;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_valid[k] = r_q[k].valid;
            w_dst[k]   = r_q[k].dst;
        end
    end

`ifdef WB_FORWARD_EN
    logic [DATA_W-1:0] w_data [DEPTH];
    always_comb begin
        for (int k = 0; k < DEPTH; k++) w_data[k] = r_q[k].data;
    end
`else
    assign fwd1 = '0;
    assign fwd2 = '0;
`endif

    hazard_match #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_hm1 (
`ifdef WB_FORWARD_EN
        .i_head(r_head), .i_data(w_data), .i_out_data(r_wdata), .o_fwd(fwd1),
`endif
        .i_valid(w_valid), .i_dst(w_dst), .i_out_valid(r_we), .i_out_reg(r_wreg),
        .i_addr(read1), .o_pending(pending1)
    );

    hazard_match #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_hm2 (
`ifdef WB_FORWARD_EN
        .i_head(r_head), .i_data(w_data), .i_out_data(r_wdata), .o_fwd(fwd2),
`endif
        .i_valid(w_valid), .i_dst(w_dst), .i_out_valid(r_we), .i_out_reg(r_wreg),
        .i_addr(read2), .o_pending(pending2)
    );
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side companion to the 32x64 register file.
- Buffers writeback results (register index plus 64-bit data) from the ALU and memory paths in a small FIFO.
- Drains the FIFO one entry per cycle onto the register file write port (writeReg/writeData/REGWRITE).
- Reports pending-write hazards for the two read addresses so decode can stall or forward.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16)
- ZERO_REG, 31, register index whose writes are discarded (XZR)

Ports:
- CLOCK  in  1  single clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  queue can accept; combinational, equals count<DEPTH
- wb_reg  in  5  destination register index
- wb_data  in  64  result data
- drain_hold  in  1  register file port busy; suppresses pop
- writeReg  out  5  registered write index to register file
- writeData  out  64  registered write data
- REGWRITE  out  1  registered write strobe, high exactly one cycle per popped entry
- read1  in  5  decode read address 1
- read2  in  5  decode read address 2
- pending1  out  1  a queued or in-flight write targets read1
- pending2  out  1  same for read2
- fwd1  out  64  youngest pending data for read1
- fwd2  out  64  youngest pending data for read2
- count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values:
  - writeReg=0, writeData=0, REGWRITE=0, count=0.
  - Head and tail pointers 0; all entry valid bits 0.
  - Reset mid-drain discards every entry and in-flight write.
- Push: on an edge with wb_valid && wb_ready.
  - If wb_reg==ZERO_REG: request accepted and dropped; no enqueue, count unchanged.
  - Otherwise: enqueue at tail, tail wraps modulo DEPTH.
- Pop: on an edge with count>0 && !drain_hold.
  - Head entry loads writeReg/writeData and REGWRITE=1; head wraps modulo DEPTH.
  - Otherwise REGWRITE=0; writeReg and writeData hold their values.
- Latency: entry pushed at edge N pops at edge N+1 at the earliest, so REGWRITE is high during cycle N+1..N+2.
- Push and pop on the same edge: both occur; count unchanged.
- Full: wb_ready=0 even if a pop occurs that edge; no bypass-on-full.
- Empty: no pop; REGWRITE=0.
- No bypass from wb_* directly to the output in the same cycle.
- Hazard lookup (combinational):
  - pendingN=1 if readN != ZERO_REG and readN matches any valid FIFO entry, or matches writeReg while REGWRITE=1.
  - Several matches: fwdN takes the youngest. Priority is newest FIFO entry (nearest tail) > older entries > in-flight output register.
  - No match: fwdN=0.
  - The incoming wb_* in the same cycle is not included.
- Duplicate destinations are allowed; drain order is strict FIFO, so the last write wins in the register file.

Optional Feature:
- Macro WB_FORWARD_EN.
  - Defined: fwd1/fwd2 behave as above.
  - Undefined: fwd1/fwd2 are driven constant 0, the youngest-match priority logic is not built, and pending1/pending2 are still generated. Decode must stall on pending.

Decomposition:
- Shared package:
  - REG_IDX_W=5, DATA_W=64, ZERO_REG_IDX=31.
  - Typedef wb_entry_t {valid, reg[4:0], data[63:0]}.
- Sub-module hazard_match:
  - Combinational compare of one read address against all entries plus the output register.
  - Returns pending and youngest data.
  - Instantiated twice (read1, read2).

Test Plan:
- Reset, then push reg 5 data 0xAA with drain_hold=0 -> REGWRITE=1, writeReg=5, writeData=0xAA one cycle after the push edge; count returns to 0.
- drain_hold=1, push reg 3/0x1, 3/0x2, 7/0x3, 9/0x4 -> count=4, wb_ready=0, fifth push not accepted; read1=3 gives pending1=1, fwd1=0x2. Release hold -> writes drain in order 3,3,7,9 on consecutive cycles.
- Push reg 31 data 0xFF -> wb_ready=1 and accepted, count stays 0, REGWRITE never asserts, pending for read1=31 is 0.
- Full queue with drain_hold=0 and wb_valid=1 every cycle -> steady state of one pop per cycle; push refused only on cycles where count==DEPTH.
- Assert RESET with 3 entries queued and REGWRITE=1 -> next cycle count=0, REGWRITE=0, pending1/2=0.
- Build with WB_FORWARD_EN undefined, queue reg 4/0x55 under hold, read2=4 -> pending2=1, fwd2=0.
